scan_chain_responder: RTL and testbench
=======================================

# scan_chain_responder

CUT-side scan chain block: the receiving end of the BIST scan interface. It holds the circuit's state flops as four parallel scan chains. Under BIST it shifts `sdi` in and `sdo` out, and captures functional next-state on demand. It also tracks load completeness and pattern count. It sits inside the scan-wrapped circuit, facing the BIST controller's LFSR (`sdi` source) and MISR (`sdo` sink).

## Interface
Parameters:
- `CHAIN_LEN`, default 14: flops per chain, legal range 2..255. Total state is 4*CHAIN_LEN bits.

Ports:
- `clk`, input, 1: single clock. All state changes on the rising edge.
- `rst`, input, 1: reset, asynchronous, active-low.
- `bistmode`, input, 1: 1 gives scan control; 0 gives functional operation.
- `scanmode`, input, 1: under `bistmode`, 1 means shift and 0 means capture.
- `sdi`, input, 4: serial input per chain; bit c feeds chain c.
- `sdo`, output, 4: serial output per chain; bit c is the tail of chain c.
- `func_d`, input, 4*CHAIN_LEN: functional next-state from the CUT logic.
- `func_q`, output, 4*CHAIN_LEN: current state flop values.
- `shift_cnt`, output, 8: shifts since the last capture, saturating at CHAIN_LEN.
- `load_ok`, output, 1: the last capture followed a full load.
- `short_load`, output, 1: sticky error. Set when any capture follows fewer than CHAIN_LEN shifts.
- `pattern_cnt`, output, 16: number of captures in this BIST session, saturating at 65535.

## Operation
- Chain c occupies `func_q[c*CHAIN_LEN +: CHAIN_LEN]`. The head is index c*CHAIN_LEN; the tail is index c*CHAIN_LEN+CHAIN_LEN-1.
- FSM states are OFF, SCAN and CAP.
  - Any state goes to OFF when `bistmode`=0.
  - OFF goes to SCAN when `bistmode`=1. This first cycle behaves as SCAN for the data path.
  - SCAN goes to CAP when `scanmode`=0.
  - CAP goes to SCAN when `scanmode`=1.
- OFF:
  - `func_q` loads `func_d` every cycle.
  - All counters and flags hold.
- Entering SCAN from OFF clears `shift_cnt`, `pattern_cnt`, `load_ok` and `short_load`. The data-path action of that edge still occurs.
- Shift (`bistmode`=1, `scanmode`=1):
  - Each chain shifts one position toward its tail, and the head loads `sdi[c]`.
  - `shift_cnt` increments, saturating at CHAIN_LEN.
- Capture (`bistmode`=1, `scanmode`=0):
  - `func_q` loads `func_d`.
  - The first capture cycle only (the SCAN to CAP edge) does the following:
    - `pattern_cnt` increments, saturating.
    - `load_ok` is set to (`shift_cnt`==CHAIN_LEN).
    - `short_load` is set if `shift_cnt`<CHAIN_LEN.
    - `shift_cnt` is cleared to 0.
  - Further consecutive capture cycles are multi-cycle functional clocking. They load `func_d` only and leave the counters unchanged.
- `sdo[c]` equals the tail flop of chain c (combinational from the flop, no logic).
- Simultaneous events: `bistmode` falling has priority over everything. That edge is a functional load, and the counters hold.
- A capture before any shift sets `short_load`.
- A shift at saturation keeps shifting data, and `shift_cnt` stays at CHAIN_LEN.

## Timing
- Reset (`rst`=0) takes effect immediately and asynchronously:
  - `func_q`=0 and `sdo`=0.
  - `shift_cnt`=0, `pattern_cnt`=0, `load_ok`=0, `short_load`=0.
  - FSM goes to OFF.
- Reset asserted mid-shift discards chain contents. After `rst` is released, the first edge with `bistmode`=1 enters SCAN.
- A bit presented on `sdi[c]` at shift edge 1 appears on `sdo[c]` after shift edge CHAIN_LEN.
- Capture latency is 1 cycle: `func_q`, `load_ok`, `pattern_cnt` and `shift_cnt` update on the capture edge.
- There is no handshake. The controller owns `scanmode` timing, and the block responds on every edge.

## Configuration
- `SCAN_SDO_RETIME_EN` defined:
  - `sdo` is registered by an extra flop per chain, with reset value 0.
  - `sdo` lags the tail flop by exactly 1 cycle.
  - A bit shifted in at edge 1 appears after edge CHAIN_LEN+1.
  - The retime flop updates every cycle, in every mode.
- `SCAN_SDO_RETIME_EN` undefined: `sdo` is a direct combinational tap of the tail flops, as described above.

## Test plan
All scenarios use CHAIN_LEN=14.
- **Reset mid-shift:** shift for 7 cycles, then pulse `rst` low between edges → all outputs read 0 before the next edge, and the FSM is in OFF.
- **Shift-through:** `bistmode`=1, `scanmode`=1, `sdi`=4'b1010 for 1 cycle then 4'b0000 for 13 cycles → after edge 14, `sdo`=4'b1010 and `shift_cnt`=14. After edge 15, `sdo`=4'b0000.
- **Full-load capture:** 14 shifts, then `scanmode`=0 for 1 cycle with `func_d` all ones → `func_q` is all ones, `pattern_cnt`=1, `load_ok`=1, `short_load`=0, `shift_cnt`=0.
- **Short load:** 5 shifts, then capture → `short_load`=1 and `load_ok`=0. A following 14-shift load and capture gives `load_ok`=1, `short_load` still 1, `pattern_cnt`=2.
- **Functional mode and session restart:**
  - With `bistmode`=0 and `func_d` toggling each cycle → `func_q` follows with 1-cycle latency, and the counters hold.
  - Raising `bistmode` → counters and flags clear on that edge.
- **Retime:** with `SCAN_SDO_RETIME_EN` defined, repeat shift-through → 4'b1010 appears on `sdo` after edge 15, not edge 14.

Source files
------------

// File: rtl/scan_chain_responder.sv
// Purpose : CUT-side scan chain block; holds the circuit state as 4 parallel scan chains.
// Latency : shift/capture act on the clock edge; sdo is a direct tap of the tail flops (+1 cycle when retimed).
// Backpr. : none; the BIST controller owns scanmode timing and the block responds on every edge.
//
// Optional feature macro: SCAN_SDO_RETIME_EN
//   defined   -> sdo is registered by one extra flop per chain (reset 0, updates every cycle).
//   undefined -> sdo is a combinational tap of the tail flop of each chain.
//
// Ports:
//   clk          single clock, all state changes on the rising edge
//   rst          asynchronous active-low reset
//   bistmode     1 = scan control, 0 = functional operation
//   scanmode     under bistmode: 1 = shift, 0 = capture
//   sdi[3:0]     serial input, bit c feeds the head of chain c
//   sdo[3:0]     serial output, bit c is the tail of chain c
//   func_d       functional next-state from the CUT logic (4*CHAIN_LEN bits)
//   func_q       current state flop values (4*CHAIN_LEN bits)
//   shift_cnt    shifts since the last capture, saturating at CHAIN_LEN
//   load_ok      last capture followed a full load
//   short_load   sticky: some capture followed fewer than CHAIN_LEN shifts
//   pattern_cnt  captures in this BIST session, saturating at 65535
//
// Chain c occupies func_q[c*CHAIN_LEN +: CHAIN_LEN]; head is the low index,
// tail is the high index. A shift moves every bit one place toward the tail.

module scan_chain_responder #(
    parameter int CHAIN_LEN = 14
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   bistmode,
    input  logic                   scanmode,
    input  logic [3:0]             sdi,
    output logic [3:0]             sdo,
    input  logic [4*CHAIN_LEN-1:0] func_d,
    output logic [4*CHAIN_LEN-1:0] func_q,
    output logic [7:0]             shift_cnt,
    output logic                   load_ok,
    output logic                   short_load,
    output logic [15:0]            pattern_cnt
);

    localparam int         W    = 4 * CHAIN_LEN;
    localparam logic [7:0] LEN8 = 8'(CHAIN_LEN);

    // ------------------------------------------------------------------
    // Session FSM
    //   OFF  : functional operation, counters hold
    //   SCAN : shifting (also the state after the session-entry edge)
    //   CAP  : capture cycles after the first one (multi-cycle functional clocking)
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_SCAN = 2'd1,
        ST_CAP  = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    // Per-edge control strobes decoded from state and mode inputs.
    logic do_shift;       // data path shifts on this edge
    logic session_start;  // OFF -> SCAN edge: counters and flags restart
    logic cap_first;      // SCAN -> CAP edge: the one edge that scores a pattern

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_OFF;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        do_shift      = 1'b0;
        session_start = 1'b0;
        cap_first     = 1'b0;

        if (!bistmode) begin
            // Dropping bistmode wins over everything: functional load, counters hold.
            state_nxt = ST_OFF;
        end else begin
            do_shift = scanmode;
            case (state)
                ST_OFF: begin
                    // Entry edge always lands in SCAN; the data path still acts
                    // on this edge according to scanmode.
                    state_nxt     = ST_SCAN;
                    session_start = 1'b1;
                end
                ST_SCAN: begin
                    if (!scanmode) begin
                        state_nxt = ST_CAP;
                        cap_first = 1'b1;
                    end
                end
                ST_CAP: begin
                    if (scanmode) begin
                        state_nxt = ST_SCAN;
                    end
                end
                default: begin
                    state_nxt = ST_OFF;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Chain data path
    // ------------------------------------------------------------------
    logic [W-1:0] shifted;
    logic [3:0]   tail;

    for (genvar c = 0; c < 4; c++) begin : g_chain
        // Bits 0..LEN-2 of the chain move up one place; sdi enters at the head.
        assign shifted[c*CHAIN_LEN +: CHAIN_LEN] = {func_q[c*CHAIN_LEN +: CHAIN_LEN-1], sdi[c]};
        assign tail[c]                           = func_q[c*CHAIN_LEN + CHAIN_LEN - 1];
    end

    // Functional mode and every capture cycle load func_d; only shift edges shift.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            func_q <= '0;
        end else if (do_shift) begin
            func_q <= shifted;
        end else begin
            func_q <= func_d;
        end
    end

    // ------------------------------------------------------------------
    // Load tracking and pattern counting
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_cnt   <= 8'd0;
            pattern_cnt <= 16'd0;
            load_ok     <= 1'b0;
            short_load  <= 1'b0;
        end else if (session_start) begin
            // New session: everything restarts, but a shift on the entry edge
            // is still the first shift of the first load.
            shift_cnt   <= do_shift ? 8'd1 : 8'd0;
            pattern_cnt <= 16'd0;
            load_ok     <= 1'b0;
            short_load  <= 1'b0;
        end else if (cap_first) begin
            if (pattern_cnt != 16'hFFFF) begin
                pattern_cnt <= pattern_cnt + 16'd1;
            end
            load_ok <= (shift_cnt == LEN8);
            if (shift_cnt < LEN8) begin
                short_load <= 1'b1;
            end
            shift_cnt <= 8'd0;
        end else if (do_shift && (shift_cnt < LEN8)) begin
            // Shifting past a full load keeps moving data but the count saturates.
            shift_cnt <= shift_cnt + 8'd1;
        end
    end

    // ------------------------------------------------------------------
    // Serial output
    // ------------------------------------------------------------------
`ifdef SCAN_SDO_RETIME_EN
    // Retime flop runs every cycle regardless of mode so sdo is always
    // exactly the tail value of the previous cycle.
    logic [3:0] sdo_r;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sdo_r <= 4'd0;
        end else begin
            sdo_r <= tail;
        end
    end

    assign sdo = sdo_r;
`else
    assign sdo = tail;
`endif

endmodule

// File: tb/tb_scan_chain_responder.sv
// Purpose : self-checking bench for scan_chain_responder (CHAIN_LEN=14).
// Latency : outputs sampled 1 time unit after each rising edge.
// Backpr. : none; stimulus is driven on every cycle.

module tb_scan_chain_responder;

    localparam int CL = 14;
    localparam int W  = 4 * CL;
`ifdef SCAN_SDO_RETIME_EN
    localparam int LAG = 1;
`else
    localparam int LAG = 0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          bistmode;
    logic          scanmode;
    logic [3:0]    sdi;
    logic [3:0]    sdo;
    logic [W-1:0]  func_d;
    logic [W-1:0]  func_q;
    logic [7:0]    shift_cnt;
    logic          load_ok;
    logic          short_load;
    logic [15:0]   pattern_cnt;

    int n_total = 0;
    int n_bad   = 0;

    scan_chain_responder #(.CHAIN_LEN(CL)) dut (
        .clk         (clk),
        .rst         (rst),
        .bistmode    (bistmode),
        .scanmode    (scanmode),
        .sdi         (sdi),
        .sdo         (sdo),
        .func_d      (func_d),
        .func_q      (func_q),
        .shift_cnt   (shift_cnt),
        .load_ok     (load_ok),
        .short_load  (short_load),
        .pattern_cnt (pattern_cnt)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model: each chain is a queue, index 0 = head.
    // ------------------------------------------------------------------
    logic       m_chain[4][$];
    bit         m_active;   // a BIST session is running
    bit         m_cap;      // previous edge was a capture inside the session
    int         m_shift;
    int         m_pat;
    bit         m_ok;
    bit         m_short;
    logic [3:0] m_sdo_r;

    task automatic model_load_func();
        for (int c = 0; c < 4; c++) begin
            m_chain[c].delete();
            for (int i = 0; i < CL; i++) m_chain[c].push_back(func_d[c*CL + i]);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < 4; c++) begin
            m_chain[c].delete();
            for (int i = 0; i < CL; i++) m_chain[c].push_back(1'b0);
        end
        m_active = 0; m_cap = 0; m_shift = 0; m_pat = 0;
        m_ok = 0; m_short = 0; m_sdo_r = 4'd0;
    endtask

    function automatic logic [W-1:0] exp_q();
        logic [W-1:0] v;
        for (int c = 0; c < 4; c++)
            for (int i = 0; i < CL; i++) v[c*CL + i] = m_chain[c][i];
        return v;
    endfunction

    function automatic logic [3:0] exp_sdo();
        logic [3:0] v;
        for (int c = 0; c < 4; c++) v[c] = m_chain[c][CL-1];
        if (LAG == 1) v = m_sdo_r;
        return v;
    endfunction

    task automatic model_edge();
        bit entering;
        bit first_cap;
        entering  = bistmode && !m_active;
        first_cap = bistmode && m_active && !scanmode && !m_cap;
        for (int c = 0; c < 4; c++) m_sdo_r[c] = m_chain[c][CL-1];
        if (!bistmode) begin
            model_load_func();
            m_active = 0;
            m_cap    = 0;
        end else begin
            if (entering) begin
                m_shift = 0; m_pat = 0; m_ok = 0; m_short = 0;
            end
            if (scanmode) begin
                for (int c = 0; c < 4; c++) begin
                    m_chain[c].push_front(sdi[c]);
                    void'(m_chain[c].pop_back());
                end
                m_shift = (m_shift < CL) ? m_shift + 1 : CL;
                m_cap   = 0;
            end else begin
                model_load_func();
                if (first_cap) begin
                    if (m_pat < 65535) m_pat++;
                    m_ok = (m_shift == CL);
                    if (m_shift < CL) m_short = 1;
                    m_shift = 0;
                end
                m_cap = !entering;
            end
            m_active = 1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b1; bistmode = 1'b0; scanmode = 1'b0; sdi = 4'd0; func_d = '0;
        #2 rst = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_total++;
        if (func_q !== '0) begin n_bad++; $display("FAIL reset_func_q got=%0h exp=0", func_q); end
        n_total++;
        if ({sdo, shift_cnt, pattern_cnt, load_ok, short_load} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs sdo=%0h shift=%0d pat=%0d ok=%0b short=%0b exp=all 0",
                     sdo, shift_cnt, pattern_cnt, load_ok, short_load);
        end
        rst = 1'b1;
    endtask

    task automatic test_reset_mid_shift();
        bistmode = 1'b1; scanmode = 1'b1;
        for (int i = 0; i < 7; i++) begin
            sdi = 4'($urandom);
            tick();
        end
        n_total++;
        if (shift_cnt !== 8'd7) begin n_bad++; $display("FAIL midshift_cnt got=%0d exp=7", shift_cnt); end
        #2 rst = 1'b0;
        #1;
        model_reset();
        n_total++;
        if (func_q !== '0 || sdo !== 4'd0) begin
            n_bad++; $display("FAIL midshift_reset_data func_q=%0h sdo=%0h exp=0", func_q, sdo);
        end
        n_total++;
        if ({shift_cnt, pattern_cnt, load_ok, short_load} !== '0) begin
            n_bad++;
            $display("FAIL midshift_reset_cnt shift=%0d pat=%0d ok=%0b short=%0b exp=0",
                     shift_cnt, pattern_cnt, load_ok, short_load);
        end
        #1 rst = 1'b1;
        // From OFF, a capture-mode edge only enters the session and must not score a pattern.
        scanmode = 1'b0; func_d = W'({$urandom(), $urandom()});
        tick();
        n_total++;
        if (pattern_cnt !== 16'd0 || short_load !== 1'b0 || func_q !== func_d) begin
            n_bad++;
            $display("FAIL midshift_entry_off pat=%0d short=%0b func_q=%0h exp pat=0 short=0 func_q=%0h",
                     pattern_cnt, short_load, func_q, func_d);
        end
    endtask

    task automatic test_shift_through();
        bistmode = 1'b0; scanmode = 1'b1; func_d = '0; sdi = 4'd0;
        tick();
        bistmode = 1'b1;
        for (int e = 1; e <= 17; e++) begin
            sdi = (e == 1) ? 4'b1010 : 4'b0000;
            tick();
            if (e == 14) begin
                n_total++;
                if (shift_cnt !== 8'd14) begin n_bad++; $display("FAIL shift_cnt_e14 got=%0d exp=14", shift_cnt); end
            end
            if (e == 16) begin
                n_total++;
                if (shift_cnt !== 8'd14) begin n_bad++; $display("FAIL shift_cnt_sat got=%0d exp=14", shift_cnt); end
            end
            if (e == 13 + LAG) begin
                n_total++;
                if (sdo !== 4'b0000) begin n_bad++; $display("FAIL sdo_early edge=%0d got=%b exp=0000", e, sdo); end
            end
            if (e == 14 + LAG) begin
                n_total++;
                if (sdo !== 4'b1010) begin n_bad++; $display("FAIL sdo_arrive edge=%0d got=%b exp=1010", e, sdo); end
            end
            if (e == 15 + LAG) begin
                n_total++;
                if (sdo !== 4'b0000) begin n_bad++; $display("FAIL sdo_after edge=%0d got=%b exp=0000", e, sdo); end
            end
        end
    endtask

    task automatic test_full_capture();
        bistmode = 1'b0; tick();
        bistmode = 1'b1; scanmode = 1'b1;
        for (int i = 0; i < CL; i++) begin sdi = 4'($urandom); tick(); end
        scanmode = 1'b0; func_d = '1;
        tick();
        n_total++;
        if (func_q !== {W{1'b1}}) begin n_bad++; $display("FAIL full_func_q got=%0h exp=all ones", func_q); end
        n_total++;
        if (pattern_cnt !== 16'd1 || load_ok !== 1'b1 || short_load !== 1'b0 || shift_cnt !== 8'd0) begin
            n_bad++;
            $display("FAIL full_counters pat=%0d ok=%0b short=%0b shift=%0d exp 1/1/0/0",
                     pattern_cnt, load_ok, short_load, shift_cnt);
        end
        // Further capture cycles are functional clocking only.
        for (int i = 0; i < 2; i++) begin
            func_d = W'({$urandom(), $urandom()});
            tick();
        end
        n_total++;
        if (func_q !== func_d || pattern_cnt !== 16'd1 || load_ok !== 1'b1 || shift_cnt !== 8'd0) begin
            n_bad++;
            $display("FAIL multicycle_cap func_q=%0h pat=%0d ok=%0b shift=%0d exp func_q=%0h pat=1 ok=1 shift=0",
                     func_q, pattern_cnt, load_ok, shift_cnt, func_d);
        end
    endtask

    task automatic test_short_load();
        bistmode = 1'b0; tick();
        bistmode = 1'b1; scanmode = 1'b1;
        for (int i = 0; i < 5; i++) begin sdi = 4'($urandom); tick(); end
        scanmode = 1'b0; tick();
        n_total++;
        if (short_load !== 1'b1 || load_ok !== 1'b0 || pattern_cnt !== 16'd1) begin
            n_bad++;
            $display("FAIL short_first short=%0b ok=%0b pat=%0d exp 1/0/1", short_load, load_ok, pattern_cnt);
        end
        scanmode = 1'b1;
        for (int i = 0; i < CL; i++) begin sdi = 4'($urandom); tick(); end
        scanmode = 1'b0; tick();
        n_total++;
        if (short_load !== 1'b1 || load_ok !== 1'b1 || pattern_cnt !== 16'd2) begin
            n_bad++;
            $display("FAIL short_then_full short=%0b ok=%0b pat=%0d exp 1/1/2", short_load, load_ok, pattern_cnt);
        end
    endtask

    task automatic test_functional_restart();
        logic [W-1:0] pat_a;
        pat_a = W'({$urandom(), $urandom()});
        bistmode = 1'b0;
        for (int i = 0; i < 6; i++) begin
            func_d = (i % 2 == 0) ? pat_a : ~pat_a;
            scanmode = 1'($urandom);
            tick();
            n_total++;
            if (func_q !== func_d) begin n_bad++; $display("FAIL func_follow cyc=%0d got=%0h exp=%0h", i, func_q, func_d); end
            n_total++;
            if (pattern_cnt !== 16'd2 || load_ok !== 1'b1 || short_load !== 1'b1 || shift_cnt !== 8'd0) begin
                n_bad++;
                $display("FAIL func_hold cyc=%0d pat=%0d ok=%0b short=%0b shift=%0d exp 2/1/1/0",
                         i, pattern_cnt, load_ok, short_load, shift_cnt);
            end
        end
        bistmode = 1'b1; scanmode = 1'b1; sdi = 4'($urandom);
        tick();
        n_total++;
        if (pattern_cnt !== 16'd0 || load_ok !== 1'b0 || short_load !== 1'b0 || shift_cnt !== 8'd1) begin
            n_bad++;
            $display("FAIL restart_clear pat=%0d ok=%0b short=%0b shift=%0d exp 0/0/0/1",
                     pattern_cnt, load_ok, short_load, shift_cnt);
        end
    endtask

    task automatic test_random();
        int left;
        left = 0;
        for (int n = 0; n < 3000; n++) begin
            if (left == 0) begin
                if (scanmode) begin
                    scanmode = 1'b0; left = $urandom_range(1, 3);
                end else begin
                    scanmode = 1'b1; left = $urandom_range(1, 18);
                end
                bistmode = ($urandom_range(0, 11) != 0);
            end
            left--;
            sdi    = 4'($urandom);
            func_d = W'({$urandom(), $urandom()});
            tick();
            n_total++;
            if (func_q !== exp_q() || sdo !== exp_sdo()) begin
                n_bad++;
                $display("FAIL rand_data cyc=%0d func_q=%0h sdo=%0h exp func_q=%0h sdo=%0h",
                         n, func_q, sdo, exp_q(), exp_sdo());
            end
            n_total++;
            if (shift_cnt !== 8'(m_shift) || pattern_cnt !== 16'(m_pat) ||
                load_ok !== m_ok || short_load !== m_short) begin
                n_bad++;
                $display("FAIL rand_cnt cyc=%0d shift=%0d pat=%0d ok=%0b short=%0b exp %0d/%0d/%0b/%0b",
                         n, shift_cnt, pattern_cnt, load_ok, short_load, m_shift, m_pat, m_ok, m_short);
            end
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_shift();
        test_shift_through();
        test_full_capture();
        test_short_load();
        test_functional_restart();
        test_random();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
